// File: rtl/uart_tx_fifo.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO, a programmable baud divisor
// and a pollable status register (DATA / STATUS / DIV at addr[3:2] = 0 / 1 / 2).
module uart_tx_fifo #(
  parameter int unsigned DEFAULT_DIV = 104,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [2:0]  write_enable,
  input  logic [3:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        uart_txd
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]  state_q,    state_d;
  logic [AW:0] wr_ptr_q,   wr_ptr_d;
  logic [AW:0] rd_ptr_q,   rd_ptr_d;
  logic        overflow_q, overflow_d;
  logic [15:0] div_q,      div_d;
  logic [7:0]  shift_q,    shift_d;
  logic [15:0] timer_q,    timer_d;
  logic [2:0]  bit_idx_q,  bit_idx_d;
  logic        txd_q,      txd_d;
  logic [7:0]  mem_q [FIFO_DEPTH];

  logic        wr_req;
  logic [1:0]  sel;
  logic [AW:0] count;
  logic [7:0]  count8;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic        bit_end;
  logic [15:0] eff_div;
  logic [7:0]  head;
  logic [31:0] rdata;
  logic        unused_ok;

  assign unused_ok = ^{data_in[31:16], addr[1:0]};

  always_comb begin
    wr_req  = en & (|write_enable);
    sel     = addr[3:2];
    count   = wr_ptr_q - rd_ptr_q;
    count8  = 8'(count);
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (count == DEPTH_CNT);
    push    = wr_req && (sel == 2'd0) && !full;
    eff_div = (div_q == 16'd0) ? 16'd1 : div_q;
    bit_end = (timer_q == 16'd1);
    head    = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    pop       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          timer_d = eff_div;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
          timer_d   = eff_div;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          timer_d = eff_div;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: begin
        // End of stop bit chains straight into the next start bit when data waits.
        if (bit_end) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            timer_d = eff_div;
            state_d = ST_START;
          end else begin
            timer_d = '0;
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
    endcase

    case (state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
    overflow_d = overflow_q;
    div_d      = div_q;
    if (wr_req && (sel == 2'd0) && full) begin
      overflow_d = 1'b1;
    end else if (wr_req && (sel == 2'd1)) begin
      overflow_d = 1'b0;
    end
    if (wr_req && (sel == 2'd2)) begin
      div_d = data_in[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      div_q      <= 16'(DEFAULT_DIV);
      shift_q    <= '0;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      div_q      <= div_d;
      shift_q    <= shift_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      txd_q      <= txd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_in[7:0];
    end
  end

  always_comb begin
    case (sel)
      2'd1:    rdata = {16'b0, count8, 4'b0, overflow_q, empty, full, (state_q != ST_IDLE)};
      2'd2:    rdata = {16'b0, div_q};
      default: rdata = '0;
    endcase
  end

  assign data_out = en ? rdata : 'z;
  assign uart_txd = txd_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: expected frames and register reads are queued by the
// stimulus and checked by independent line and bus monitors.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [2:0]  write_enable = '0;
  logic [3:0]  addr = '0;
  logic [31:0] data_in = '0;
  wire  [31:0] data_out;
  logic        uart_txd;
  logic        probe = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0] data;
    int         len_a;
    int         len_b;
    int         split;
    int         start;
    bit         aborted;
  } frame_t;

  typedef struct {
    logic [31:0] val;
    string       name;
  } rd_t;

  frame_t fq[$];
  rd_t    rq[$];

  uart_tx_fifo #(.DEFAULT_DIV(104), .FIFO_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .en(en), .write_enable(write_enable),
    .addr(addr), .data_in(data_in), .data_out(data_out), .uart_txd(uart_txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [2:0] we);
    en = 1'b1; write_enable = we; addr = a; data_in = d;
    step();
    en = 1'b0; write_enable = '0;
  endtask

  task automatic rd(input string name, input logic [3:0] a, input logic [31:0] val);
    rd_t r;
    r.val = val; r.name = name;
    rq.push_back(r);
    en = 1'b1; write_enable = '0; addr = a;
    step();
    en = 1'b0;
  endtask

  task automatic probe_z(input string name);
    rd_t r;
    r.val = 'z; r.name = name;
    rq.push_back(r);
    probe = 1'b1;
    step();
    probe = 1'b0;
  endtask

  task automatic exp_frame(input logic [7:0] d, input int la, input int lb, input int split,
                           input int start, input bit ab);
    frame_t f;
    f.data = d; f.len_a = la; f.len_b = lb; f.split = split; f.start = start; f.aborted = ab;
    fq.push_back(f);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Bus read monitor
  initial begin : read_mon
    rd_t r;
    forever begin
      @(negedge clk);
      if ((en && write_enable == 3'b000) || probe) begin
        total++;
        if (rq.size() == 0) begin
          bad++;
          $display("FAIL read_unexpected: data_out=%h required no read", data_out);
        end else begin
          r = rq.pop_front();
          if (data_out !== r.val) begin
            bad++;
            $display("FAIL %s: data_out=%h required %h", r.name, data_out, r.val);
          end
        end
      end
    end
  end

  // Serial line monitor
  initial begin : line_mon
    frame_t e;
    int     start_c, len, fb, fc;
    logic   lvl, fv;
    bit     ok, aborted, first;
    forever begin
      @(negedge clk);
      if (!reset && uart_txd === 1'b0) begin
        start_c = cyc;
        total++;
        if (fq.size() == 0) begin
          bad++;
          $display("FAIL frame_unexpected: start at cycle %0d, required none", start_c);
          while (uart_txd === 1'b0 && !reset) @(negedge clk);
        end else begin
          e = fq.pop_front();
          ok = 1'b1; aborted = 1'b0; first = 1'b1; fb = 0; fc = 0; fv = 1'b0;
          for (int b = 0; b < 10 && !aborted; b++) begin
            lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : e.data[b-1];
            len = (b < e.split) ? e.len_a : e.len_b;
            for (int c = 0; c < len && !aborted; c++) begin
              if (!first) @(negedge clk);
              first = 1'b0;
              if (reset) aborted = 1'b1;
              else if (uart_txd !== lvl && ok) begin
                ok = 1'b0; fb = b; fc = c; fv = uart_txd;
              end
            end
          end
          if (!ok || aborted != e.aborted) begin
            bad++;
            $display("FAIL frame_%h: bit %0d cycle %0d txd=%b aborted=%0d, required txd=%b aborted=%0d",
                     e.data, fb, fc, fv, aborted, (fb == 0) ? 1'b0 : (fb == 9) ? 1'b1 : e.data[fb-1],
                     e.aborted);
          end
          total++;
          if (start_c != e.start) begin
            bad++;
            $display("FAIL frame_start_%h: cycle=%0d required %0d", e.data, start_c, e.start);
          end
          if (aborted) begin
            @(negedge clk);
            total++;
            if (uart_txd !== 1'b1) begin
              bad++;
              $display("FAIL txd_after_reset: txd=%b required 1", uart_txd);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int e0, e1;
    repeat (3) step();
    reset = 1'b0;

    // Reset state and register map
    rd("status_reset", 4'h4, 32'h0000_0004);
    rd("div_reset",    4'h8, 32'd104);
    rd("data_reads0",  4'h0, 32'h0);
    wr(4'hC, 32'hFFFF_FFFF, 3'b001);
    rd("reg3_reads0",  4'hC, 32'h0);
    probe_z("data_out_hiz");

    // 0x55 at DIV=4, byte write
    wr(4'h8, 32'd4, 3'b001);
    exp_frame(8'h55, 4, 4, 10, cyc + 2, 1'b0);
    wr(4'h0, 32'hFFFF_FF55, 3'b100);
    e0 = cyc;
    rd("status_queued", 4'h4, 32'h0000_0100);
    wait_until(e0 + 40);
    rd("status_last_busy", 4'h4, 32'h0000_0005);
    rd("status_idle",      4'h4, 32'h0000_0004);

    // Back-to-back word writes at DIV=2
    wr(4'h8, 32'd2, 3'b001);
    exp_frame(8'hA5, 2, 2, 10, cyc + 2, 1'b0);
    exp_frame(8'h3C, 2, 2, 10, cyc + 22, 1'b0);
    wr(4'h0, 32'h0000_00A5, 3'b001);
    wr(4'h0, 32'h0000_003C, 3'b001);
    e0 = cyc;
    wait_until(e0 + 45);
    rd("status_after_pair", 4'h4, 32'h0000_0004);

    // Overflow with serialiser held busy
    wr(4'h8, 32'h0000_FFFF, 3'b001);
    exp_frame(8'h01, 65535, 65535, 10, cyc + 2, 1'b1);
    for (int i = 1; i <= 18; i++) wr(4'h0, 32'(i), 3'b100);
    rd("status_full_ovf", 4'h4, 32'h0000_100B);
    wr(4'h4, 32'h0, 3'b001);
    rd("status_ovf_clr",  4'h4, 32'h0000_1003);
    pulse_reset();
    rd("status_post_rst", 4'h4, 32'h0000_0004);
    rd("div_post_rst",    4'h8, 32'd104);

    // DIV change during bit 3 of a DIV=8 frame, half write
    wr(4'h8, 32'd8, 3'b010);
    exp_frame(8'h96, 8, 2, 5, cyc + 2, 1'b0);
    wr(4'h0, 32'h0000_0096, 3'b100);
    e0 = cyc;
    wait_until(e0 + 35);
    wr(4'h8, 32'd2, 3'b001);
    wait_until(e0 + 60);
    rd("div_changed", 4'h8, 32'd2);
    rd("status_after_div", 4'h4, 32'h0000_0004);

    // Reset during DATA with 3 bytes queued
    exp_frame(8'h11, 2, 2, 10, cyc + 2, 1'b1);
    wr(4'h0, 32'h11, 3'b100);
    e1 = cyc;
    wr(4'h0, 32'h22, 3'b100);
    wr(4'h0, 32'h33, 3'b100);
    wr(4'h0, 32'h44, 3'b100);
    rd("status_3_queued", 4'h4, 32'h0000_0301);
    wait_until(e1 + 6);
    pulse_reset();
    rd("status_abort", 4'h4, 32'h0000_0004);
    repeat (100) step();

    e0 = cyc;
    while ((fq.size() != 0 || rq.size() != 0) && cyc < e0 + 2000) step();
    total++;
    if (fq.size() != 0 || rq.size() != 0) begin
      bad++;
      $display("FAIL drain: pending frames=%0d reads=%0d required 0 and 0", fq.size(), rq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
